exec_skid_stage: RTL

// - Parametrised elastic pipeline register between execute and writeback.
// - Carries ALU result, register-write enable and destination register index.
// - Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready comes straight from a flop.
// - Supports flush (squash), and can be chained for deeper pipelines.

---
 rtl/exec_pipe_pkg.sv | 28 ++
 rtl/exec_stage_sat_cnt.sv | 30 +++
 rtl/exec_skid_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/exec_pipe_pkg.sv
// Shared types for the execute/writeback pipeline: widths, skid occupancy states, writeback entry.
package exec_pipe_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   typedef struct packed {
      logic [XLEN-1:0]      data;
      logic                 wr_en;
      logic [REG_IDX_W-1:0] rd;
   } wb_entry_t;

   // Number of valid entries held in a given occupancy state.
   function automatic logic [1:0] occ_count(occ_e occ);
      unique case (occ)
         OCC_ONE:  occ_count = 2'd1;
         OCC_FULL: occ_count = 2'd2;
         default:  occ_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/exec_stage_sat_cnt.sv
// Saturating statistics counter: adds a small increment each cycle and sticks at all-ones.
module exec_stage_sat_cnt #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned INC_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [INC_W-1:0] inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum;

   always_comb begin
      sum   = {1'b0, cnt_q} + {{(CNT_W + 1 - INC_W){1'b0}}, inc_i};
      cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/exec_skid_stage.sv
// Execute-to-writeback elastic register with a 2-entry skid buffer and flush.
// Optional statistics counters are built when EXEC_STAGE_STATS_EN is defined.
module exec_skid_stage
   import exec_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = XLEN,
   parameter int unsigned RD_W   = REG_IDX_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_wr_en,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_wr_en,
   output logic [RD_W-1:0]   out_rd
`ifdef EXEC_STAGE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   // Same layout as wb_entry_t, sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              wr_en;
      logic [RD_W-1:0]   rd;
   } entry_t;

   if (CNT_W < 2) begin : g_bad_cnt_w
      $error("CNT_W must be at least 2");
   end

   occ_e   state_q, state_d;
   logic   in_ready_q, in_ready_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t in_entry;
   logic   accept, drain;

   assign in_entry  = '{data: in_data, wr_en: in_wr_en, rd: in_rd};
   assign accept    = in_valid & in_ready_q;
   assign out_valid = (state_q != OCC_EMPTY);
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         // Payload registers keep their contents; only occupancy is cleared.
         state_d = OCC_EMPTY;
      end else begin
         unique case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  state_d = OCC_ONE;
                  head_d  = in_entry;
               end
            end
            OCC_ONE: begin
               if (accept && drain) begin
                  head_d = in_entry;
               end else if (drain) begin
                  state_d = OCC_EMPTY;
               end else if (accept) begin
                  state_d = OCC_FULL;
                  skid_d  = in_entry;
               end
            end
            OCC_FULL: begin
               if (drain) begin
                  state_d = OCC_ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
      in_ready_d = (state_d != OCC_FULL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= OCC_EMPTY;
         in_ready_q <= 1'b1;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_data  = head_q.data;
   assign out_rd    = head_q.rd;
   // x0 is hardwired zero, so writes to it are dropped here.
   assign out_wr_en = head_q.wr_en & out_valid & (head_q.rd != '0);

`ifdef EXEC_STAGE_STATS_EN
   logic [1:0] stall_inc, flush_inc;

   assign stall_inc = {1'b0, out_valid & ~out_ready};
   assign flush_inc = flush ? occ_count(state_q) : 2'd0;

   exec_stage_sat_cnt #(
      .CNT_W (CNT_W),
      .INC_W (2)
   ) u_stall_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .inc_i  (stall_inc),
      .cnt_o  (stall_cnt)
   );

   exec_stage_sat_cnt #(
      .CNT_W (CNT_W),
      .INC_W (2)
   ) u_flush_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .inc_i  (flush_inc),
      .cnt_o  (flush_cnt)
   );
`endif

endmodule
